// File: rtl/haz_pkg.sv
// Shared defaults, the per-stage scoreboard entry and forward-select encoding
// for the hazard scoreboard.
package haz_pkg;
  localparam int NREG_DEF     = 32;
  localparam int NSTAGE_DEF   = 3;
  localparam int LOAD_LAT_DEF = 2;
  // Storage width for a destination register number; covers NREG up to 256.
  localparam int TD_W         = 8;
  localparam int FWD_RF       = 0;

  typedef struct packed {
    logic            valid;
    logic [TD_W-1:0] td;
    logic            lw;
  } haz_entry_t;
endpackage

// File: rtl/hazard_cmp.sv
// Per-source match against all tracked stages: youngest match wins, and a
// load that has not yet reached its forwarding stage flags a hazard.
module hazard_cmp
  import haz_pkg::*;
#(
  parameter int NSTAGE   = NSTAGE_DEF,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int RW       = 5,
  parameter int SW       = 2
) (
  input  haz_entry_t [NSTAGE:1] ent,
  input  logic [RW-1:0]         src,
  input  logic                  used,
  output logic [SW-1:0]         sel,
  output logic                  load_hzd
);

  logic hit_s;

  // Scan oldest to youngest so the smallest matching stage is written last.
  always_comb begin
    sel      = SW'(FWD_RF);
    load_hzd = 1'b0;
    hit_s    = 1'b0;
    for (int k = NSTAGE; k >= 1; k--) begin
      hit_s    = used && (src != RW'(0)) && ent[k].valid && (ent[k].td == TD_W'(src));
      sel      = hit_s ? SW'(k) : sel;
      load_hzd = hit_s ? (ent[k].lw && (k < LOAD_LAT)) : load_hzd;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks destinations of in-flight instructions,
// drives forwarding selects and load-use stalls. Optional stall counter is
// built only when HAZ_PERF_CNT_EN is defined.
module hazard_scoreboard
  import haz_pkg::*;
#(
  parameter int  NREG     = NREG_DEF,
  parameter int  NSTAGE   = NSTAGE_DEF,
  parameter int  LOAD_LAT = LOAD_LAT_DEF,
  localparam int RW       = $clog2(NREG),
  localparam int SW       = $clog2(NSTAGE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic [RW-1:0] id_td,
  input  logic          id_wreg,
  input  logic          id_lw,
  input  logic          flush,
  output logic          stall,
  output logic          issue,
  output logic [SW-1:0] fwd_rs_sel,
  output logic [SW-1:0] fwd_rt_sel,
  output logic [15:0]   stall_cnt
);

  haz_entry_t [NSTAGE:1] ent_r;
  haz_entry_t            ent_new_s;
  logic                  rs_hzd_s;
  logic                  rt_hzd_s;
  logic                  stall_s;
  logic                  issue_s;

  hazard_cmp #(.NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT), .RW(RW), .SW(SW)) u_cmp_rs (
    .ent      (ent_r),
    .src      (id_rs),
    .used     (id_rs_used),
    .sel      (fwd_rs_sel),
    .load_hzd (rs_hzd_s)
  );

  hazard_cmp #(.NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT), .RW(RW), .SW(SW)) u_cmp_rt (
    .ent      (ent_r),
    .src      (id_rt),
    .used     (id_rt_used),
    .sel      (fwd_rt_sel),
    .load_hzd (rt_hzd_s)
  );

  // Flush masks the stall so a killed instruction never holds the front end.
  assign stall_s = id_valid & ~flush & (rs_hzd_s | rt_hzd_s);
  assign issue_s = id_valid & ~stall_s & ~flush;
  assign stall   = stall_s;
  assign issue   = issue_s;

  // New stage-1 entry: only issued register writers with a nonzero target.
  always_comb begin
    ent_new_s = '0;
    if (issue_s && (id_wreg || id_lw) && (id_td != RW'(0))) begin
      ent_new_s.valid = 1'b1;
      ent_new_s.td    = TD_W'(id_td);
      ent_new_s.lw    = id_lw;
    end else begin
      ent_new_s = '0;
    end
  end

  // Stage shift register; the oldest entry falls off the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_r <= '0;
    end else begin
      ent_r[1] <= ent_new_s;
      for (int k = 2; k <= NSTAGE; k++) begin
        ent_r[k] <= ent_r[k-1];
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (NSTAGE=3, LOAD_LAT=2); stall_cnt
// expectations follow HAZ_PERF_CNT_EN.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic [4:0]  id_td;
  logic        id_wreg;
  logic        id_lw;
  logic        flush;
  logic        stall;
  logic        issue;
  logic [1:0]  fwd_rs_sel;
  logic [1:0]  fwd_rt_sel;
  logic [15:0] stall_cnt;

  int total_cnt = 0;
  int pass_cnt  = 0;

`ifdef HAZ_PERF_CNT_EN
  localparam int CNT_ONE = 1;
`else
  localparam int CNT_ONE = 0;
`endif

  hazard_scoreboard #(.NREG(32), .NSTAGE(3), .LOAD_LAT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rs_used (id_rs_used),
    .id_rt_used (id_rt_used),
    .id_td      (id_td),
    .id_wreg    (id_wreg),
    .id_lw      (id_lw),
    .flush      (flush),
    .stall      (stall),
    .issue      (issue),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic [4:0] td,
                       input logic wr, input logic lw, input logic fl);
    id_valid   = v;
    id_rs      = rs;
    id_rs_used = rsu;
    id_rt      = rt;
    id_rt_used = rtu;
    id_td      = td;
    id_wreg    = wr;
    id_lw      = lw;
    flush      = fl;
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rs_sel", 32'(fwd_rs_sel), 32'd0);
    chk("rst_rt_sel", 32'(fwd_rt_sel), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_issue", 32'(issue), 32'd0);

    // Test 1: ALU result forwarded from EX, then from stage 2
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("t1_issue", 32'(issue), 32'd1);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t1_rs_sel1", 32'(fwd_rs_sel), 32'd1);
    chk("t1_rt_unused", 32'(fwd_rt_sel), 32'd0);
    chk("t1_stall", 32'(stall), 32'd0);
    tick();
    chk("t1_rs_sel2", 32'(fwd_rs_sel), 32'd2);
    drain();

    // Test 2: load-use stall of exactly one cycle
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    chk("t2_lw_issue", 32'(issue), 32'd1);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t2_stall", 32'(stall), 32'd1);
    chk("t2_no_issue", 32'(issue), 32'd0);
    tick();
    chk("t2_stall_clr", 32'(stall), 32'd0);
    chk("t2_rt_sel", 32'(fwd_rt_sel), 32'd2);
    chk("t2_issue", 32'(issue), 32'd1);
    chk("t2_cnt", 32'(stall_cnt), 32'(CNT_ONE));
    tick();
    drain();

    // Test 3: writes to register 0 are never tracked
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t3_rs_sel", 32'(fwd_rs_sel), 32'd0);
    chk("t3_stall", 32'(stall), 32'd0);
    chk("t3_ent1", 32'(dut.ent_r[1].valid), 32'd0);
    drain();

    // Test 4: youngest of two writers to the same register wins
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t4_rs_sel", 32'(fwd_rs_sel), 32'd1);
    id_valid = 1'b0;
    tick();
    chk("t4_rs_sel_s2", 32'(fwd_rs_sel), 32'd2);
    drain();

    // Test 5: flush overrides a pending load hazard
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    chk("t5_stall", 32'(stall), 32'd0);
    chk("t5_issue", 32'(issue), 32'd0);
    tick();
    drive(1'b0, 5'd6, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t5_ent1", 32'(dut.ent_r[1].valid), 32'd0);
    chk("t5_cnt", 32'(stall_cnt), 32'(CNT_ONE));
    chk("t5_rs_sel", 32'(fwd_rs_sel), 32'd2);
    chk("t5_rt_killed", 32'(fwd_rt_sel), 32'd0);
    drain();

    // Test 6: reset in the middle of a stall
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("t6_stall_pre", 32'(stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_stall", 32'(stall), 32'd0);
    chk("t6_rs_sel", 32'(fwd_rs_sel), 32'd0);
    chk("t6_rt_sel", 32'(fwd_rt_sel), 32'd0);
    chk("t6_cnt", 32'(stall_cnt), 32'd0);
    chk("t6_issue", 32'(issue), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
